// File: rtl/updown_counter.sv
// Up/down modulus counter with enable prescaler, synchronous load, wrap/saturate mode and terminal-count pulse.
// Latency: q and tc update on the tick edge; hex is combinational from q.
// Backpressure: none; load overrides a same-edge tick and restarts the prescaler.
module updown_counter #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = longint'(1) << WIDTH,
  parameter int     PRESCALE = 1,
  localparam int    NDIG     = (WIDTH + 3) / 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                up,
  input  logic                sat,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    q,
  output logic                tc,
  output logic [7*NDIG-1:0]   hex
);

  // Largest legal count; held in WIDTH bits so MODULUS = 2**WIDTH never overflows.
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam int               PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0]   PC_LAST = PCW'(PRESCALE - 1);

  logic [PCW-1:0]    pc;
  logic              tick;
  logic              at_bound;
  logic [WIDTH-1:0]  q_step;
  logic [WIDTH-1:0]  load_clamped;
  logic [4*NDIG-1:0] q_ext;

  // A count step happens on the last enabled prescaler cycle, unless a load claims the edge.
  assign tick = en && !load && (pc == PC_LAST);

  // Next count for a tick, plus whether this tick sits on the bound for the current direction.
  always_comb begin
    at_bound = 1'b0;
    q_step   = q;
    if (up) begin
      if (q < MAXV) begin
        q_step = q + WIDTH'(1);
      end else begin
        at_bound = 1'b1;
        q_step   = sat ? q : '0;
      end
    end else begin
      if (q != '0) begin
        q_step = q - WIDTH'(1);
      end else begin
        at_bound = 1'b1;
        q_step   = sat ? q : MAXV;
      end
    end
  end

  // Out-of-range load values pin to the top of the count range.
  assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

  // Prescaler phase: restarts on load, holds while disabled.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc <= '0;
    end else if (load) begin
      pc <= '0;
    end else if (en) begin
      if (pc == PC_LAST) pc <= '0;
      else               pc <= pc + PCW'(1);
    end
  end

  // Count register and one-cycle terminal-count pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= load_clamped;
      tc <= 1'b0;
    end else if (tick) begin
      q  <= q_step;
      tc <= at_bound;
    end else begin
      tc <= 1'b0;
    end
  end

  // Active-low segment pattern (bit 0 = a ... bit 6 = g), lowercase b and d.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Top digit of a non-multiple-of-4 width is zero-extended.
  assign q_ext = (4*NDIG)'(q);

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign hex[7*g +: 7] = seg7(q_ext[4*g +: 4]);
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: four configurations share one stimulus stream.
// Expected q/tc are pushed to a scoreboard as each edge is driven and popped after it.
// Directed constant checks cover the boundary cases of each configuration.
module tb_updown_counter;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
  logic [7:0]  load_val = 8'h00;

  logic [7:0]  q0, q2, q3;
  logic [3:0]  q1;
  logic        tc0, tc1, tc2, tc3;
  logic [13:0] hex0, hex2, hex3;
  logic [6:0]  hex1;

  always #5 clk = ~clk;

  // d0: full 8-bit range; d1: decade counter; d2: mod-100; d3: full range, prescale 4
  updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) d0 (
    .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(q0), .tc(tc0), .hex(hex0));
  updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) d1 (
    .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[3:0]), .q(q1), .tc(tc1), .hex(hex1));
  updown_counter #(.WIDTH(8), .MODULUS(100), .PRESCALE(1)) d2 (
    .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(q2), .tc(tc2), .hex(hex2));
  updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(4)) d3 (
    .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(q3), .tc(tc3), .hex(hex3));

  int W   [4] = '{8, 4, 8, 8};
  int MOD [4] = '{256, 10, 100, 256};
  int PRE [4] = '{1, 1, 1, 4};
  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int mq [4];
  int mpc[4];
  int mtc[4];

  typedef struct packed { logic [7:0] q; logic tc; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] dut_q(input int i);
    case (i)
      0: return {8'h0, q0};
      1: return {12'h0, q1};
      2: return {8'h0, q2};
      default: return {8'h0, q3};
    endcase
  endfunction

  function automatic logic [15:0] dut_tc(input int i);
    case (i)
      0: return {15'h0, tc0};
      1: return {15'h0, tc1};
      2: return {15'h0, tc2};
      default: return {15'h0, tc3};
    endcase
  endfunction

  function automatic logic [15:0] dut_hex(input int i);
    case (i)
      0: return {2'b0, hex0};
      1: return {9'h0, hex1};
      2: return {2'b0, hex2};
      default: return {2'b0, hex3};
    endcase
  endfunction

  function automatic logic [15:0] exp_hex(input int i, input logic [7:0] v);
    logic [3:0] lo, hi;
    lo = v[3:0];
    hi = v[7:4];
    if (i == 1) return {9'h0, SEG[lo]};
    return {2'b0, SEG[hi], SEG[lo]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    assert (act === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; mpc[i] = 0; mtc[i] = 0;
    end
  endtask

  // Reference behaviour for one rising edge, applied to every configuration.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int lv;
      bit tk;
      exp_t e;
      tk = 1'b0;
      if (load) begin
        lv = int'(load_val) & ((1 << W[i]) - 1);
        mq[i]  = (lv >= MOD[i]) ? MOD[i] - 1 : lv;
        mpc[i] = 0;
        mtc[i] = 0;
      end else begin
        if (en) begin
          if (mpc[i] == PRE[i] - 1) begin tk = 1'b1; mpc[i] = 0; end
          else mpc[i] = mpc[i] + 1;
        end
        mtc[i] = 0;
        if (tk) begin
          if (up) begin
            if (mq[i] == MOD[i] - 1) begin mtc[i] = 1; if (!sat) mq[i] = 0; end
            else mq[i] = mq[i] + 1;
          end else begin
            if (mq[i] == 0) begin mtc[i] = 1; if (!sat) mq[i] = MOD[i] - 1; end
            else mq[i] = mq[i] - 1;
          end
        end
      end
      e.q  = 8'(mq[i]);
      e.tc = mtc[i][0];
      sb.push_back(e);
    end
  endtask

  // Drive one edge with the current inputs and check every configuration after it.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      chk($sformatf("q%0d", i),   dut_q(i),   {8'h0, e.q});
      chk($sformatf("tc%0d", i),  dut_tc(i),  {15'h0, e.tc});
      chk($sformatf("hex%0d", i), dut_hex(i), exp_hex(i, e.q));
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_q%0d", tag, i),   dut_q(i),   16'h0);
      chk($sformatf("%s_tc%0d", tag, i),  dut_tc(i),  16'h0);
      chk($sformatf("%s_hex%0d", tag, i), dut_hex(i), (i == 1) ? 16'h0040 : 16'h2040);
    end
  endtask

  initial begin
    // Power-on reset
    model_reset();
    #1;
    chk_all_zero("por");
    #2 clr = 1'b1;

    // Count to 0x37, advance part way through a prescale period, then reset asynchronously
    en = 1'b1; up = 1'b1; sat = 1'b0;
    do_load(8'h37);
    step();
    step();
    #2 clr = 1'b0;
    #1;
    model_reset();
    chk_all_zero("async_rst");
    #1 clr = 1'b1;
    step();
    chk("reset_resume", dut_q(0), 16'h1);

    // Wrap up through the decade boundary
    do_load(8'h00);
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 9) chk("dec_nine_seg", dut_hex(1), 16'h0010);
      if (k == 10) begin
        chk("dec_wrap_q", dut_q(1), 16'h0);
        chk("dec_wrap_tc", dut_tc(1), 16'h1);
      end
    end

    // Down with wrap, then down with saturate
    up = 1'b0; sat = 1'b0;
    do_load(8'h02);
    for (int k = 1; k <= 3; k++) step();
    chk("down_wrap_q", dut_q(1), 16'h9);
    chk("down_wrap_tc", dut_tc(1), 16'h1);
    sat = 1'b1;
    do_load(8'h02);
    for (int k = 1; k <= 4; k++) step();
    chk("down_sat_q", dut_q(1), 16'h0);
    chk("down_sat_tc", dut_tc(1), 16'h1);

    // Load beats a same-edge tick and clamps; the next tick wraps from the top
    up = 1'b1; sat = 1'b0;
    do_load(8'd5);
    do_load(8'd200);
    chk("load_clamp_q", dut_q(2), 16'd99);
    chk("load_clamp_tc", dut_tc(2), 16'h0);
    step();
    chk("load_wrap_q", dut_q(2), 16'h0);
    chk("load_wrap_tc", dut_tc(2), 16'h1);

    // Prescaler: step every 4th enabled edge, phase held across a 3-cycle enable gap
    do_load(8'h00);
    for (int k = 1; k <= 6; k++) step();
    chk("pre_first", dut_q(3), 16'h1);
    en = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    en = 1'b1;
    step();
    chk("pre_hold", dut_q(3), 16'h1);
    step();
    chk("pre_next", dut_q(3), 16'h2);
    for (int k = 1; k <= 4; k++) step();

    // Full-width wrap through FF
    do_load(8'hFE);
    step();
    chk("full_ff_seg", dut_hex(0), 16'h070E);
    step();
    chk("full_wrap_q", dut_q(0), 16'h0);
    chk("full_wrap_tc", dut_tc(0), 16'h1);
    chk("full_wrap_seg", dut_hex(0), 16'h2040);

    // Mixed traffic
    for (int k = 0; k < 400; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) != 0;
      sat      = $urandom_range(0, 1) != 0;
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      step();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
